ws2812_send: RTL and testbench

- Serialises a frame of WS_NUM RGB888 colours onto a single-wire WS2812 data line, ending with a reset/latch gap.
- Sits directly upstream of the WS2812 receive/decode stage; its data_stream output drives that stage's data_stream input or a physical LED chain.
- Wire timing is centred inside the receiver's tolerance windows: 0H 150–450 ns, 1H 600–900 ns, low 600–900 ns, reset ≥80 µs.

---
 rtl/ws2812_send.sv | 144 ++++++++++++++
 tb/tb_ws2812_send.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_send.sv
// WS2812 frame transmitter: serialises WS_NUM RGB888 colours (sent as GRB, MSB first)
// onto a single-wire data line and finishes with a reset/latch low gap.
`timescale 1ns/1ps
module ws2812_send #(
    parameter int unsigned DEPTH   = 24,
    parameter int unsigned CLKHZ   = 50_000_000,
    parameter int unsigned WS_NUM  = 7,
    parameter int unsigned T0H_NS  = 300,
    parameter int unsigned T1H_NS  = 750,
    parameter int unsigned TL_NS   = 750,
    parameter int unsigned TRST_NS = 100_000
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [DEPTH*WS_NUM-1:0]   color_in,
    output logic                      busy,
    output logic                      done,
    output logic                      data_stream
);

    localparam int unsigned NS_PER_CLK = 1_000_000_000 / CLKHZ;
    localparam int unsigned C0H        = T0H_NS / NS_PER_CLK;
    localparam int unsigned C1H        = T1H_NS / NS_PER_CLK;
    localparam int unsigned CL         = TL_NS / NS_PER_CLK;
    localparam int unsigned CRST       = TRST_NS / NS_PER_CLK;
    localparam int unsigned CW         = ($clog2(CRST + 1) > 16) ? $clog2(CRST + 1) : 16;
    localparam int unsigned TOTAL      = DEPTH * WS_NUM;
    localparam int unsigned BW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW         = (WS_NUM > 1) ? $clog2(WS_NUM) : 1;

    typedef enum logic [1:0] {IDLE, HIGH, LOW, RST} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [BW-1:0]     bit_cnt, bit_nxt;
    logic [LW-1:0]     led_cnt, led_nxt;
    logic [TOTAL-1:0]  sr, sr_nxt;
    logic [TOTAL-1:0]  wire_in;
    logic              done_nxt;
    logic              last_bit;

    // Frame buffer holds LED0 in the top word, each word reordered to GRB so the
    // line is driven straight from the MSB of a left shift register.
    function automatic logic [TOTAL-1:0] to_wire(input logic [TOTAL-1:0] c);
        logic [TOTAL-1:0] w;
        logic [DEPTH-1:0] word;
        w = '0;
        for (int unsigned i = 0; i < WS_NUM; i++) begin
            word = c[i*DEPTH +: DEPTH];
            w[(WS_NUM-1-i)*DEPTH +: DEPTH] = {word[DEPTH-9 -: 8], word[DEPTH-1 -: 8], word[DEPTH-17:0]};
        end
        return w;
    endfunction

    function automatic logic [CW-1:0] high_len(input logic b);
        return b ? CW'(C1H - 1) : CW'(C0H - 1);
    endfunction

    always_comb wire_in = to_wire(color_in);

    assign last_bit = (bit_cnt == BW'(DEPTH - 1)) && (led_cnt == LW'(WS_NUM - 1));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_cnt;
        led_nxt   = led_cnt;
        sr_nxt    = sr;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    sr_nxt    = wire_in;
                    bit_nxt   = '0;
                    led_nxt   = '0;
                    cnt_nxt   = high_len(sr_nxt[TOTAL-1]);
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    state_nxt = LOW;
                    cnt_nxt   = CW'(CL - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            LOW: begin
                if (cnt == '0) begin
                    if (last_bit) begin
                        state_nxt = RST;
                        cnt_nxt   = CW'(CRST - 1);
                    end else begin
                        state_nxt = HIGH;
                        sr_nxt    = sr << 1;
                        cnt_nxt   = high_len(sr_nxt[TOTAL-1]);
                        if (bit_cnt == BW'(DEPTH - 1)) begin
                            bit_nxt = '0;
                            led_nxt = led_cnt + LW'(1);
                        end else begin
                            bit_nxt = bit_cnt + BW'(1);
                        end
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RST: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            led_cnt     <= '0;
            sr          <= '0;
            data_stream <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bit_cnt     <= bit_nxt;
            led_cnt     <= led_nxt;
            sr          <= sr_nxt;
            data_stream <= (state_nxt == HIGH);
            busy        <= (state_nxt != IDLE);
            done        <= done_nxt;
        end
    end

endmodule

// File: tb/tb_ws2812_send.sv
// Scoreboard bench for ws2812_send: decodes the wire per frame and checks colours,
// pulse widths, frame length and inter-frame gaps against queued expectations.
`timescale 1ns/1ps
module tb_ws2812_send;

    localparam int unsigned C0H  = 15;
    localparam int unsigned C1H  = 37;
    localparam int unsigned CL   = 37;
    localparam int unsigned CRST = 5000;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic         rstn1, start1, busy1, done1, ds1;
    logic [23:0]  col1;
    logic         rstn7, start7, busy7, done7, ds7;
    logic [167:0] col7;

    ws2812_send #(.WS_NUM(1)) dut1 (
        .clk(clk), .rstn(rstn1), .start(start1), .color_in(col1),
        .busy(busy1), .done(done1), .data_stream(ds1)
    );

    ws2812_send #(.WS_NUM(7)) dut7 (
        .clk(clk), .rstn(rstn7), .start(start7), .color_in(col7),
        .busy(busy7), .done(done7), .data_stream(ds7)
    );

    logic ds_v [2];
    logic busy_v [2];
    logic done_v [2];
    logic rstn_v [2];
    assign ds_v[0]   = ds1;
    assign ds_v[1]   = ds7;
    assign busy_v[0] = busy1;
    assign busy_v[1] = busy7;
    assign done_v[0] = done1;
    assign done_v[1] = done7;
    assign rstn_v[0] = rstn1;
    assign rstn_v[1] = rstn7;

    typedef struct {
        logic [167:0] cols;
        int unsigned  nleds;
        int unsigned  len;
        int unsigned  gap;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string name, input longint unsigned got, input longint unsigned want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    function automatic int unsigned frame_len(input logic [167:0] c, input int unsigned n);
        int unsigned ones = 0;
        for (int unsigned i = 0; i < n * 24; i++) ones += int'(c[i]);
        return ones * (C1H + CL) + (n * 24 - ones) * (C0H + CL) + CRST;
    endfunction

    task automatic push(input int d, input logic [167:0] c, input int unsigned n,
                        input int unsigned len, input int unsigned gap);
        exp_t e;
        e.cols = c; e.nleds = n; e.len = len; e.gap = gap;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic monitor(input int d);
        bit           act = 0;
        bit           have;
        logic         pds = 1'b0, pdone = 1'b0;
        int unsigned  rise_c = 0, fall_c = 0, start_c = 0, gap = 0, nb = 0, hw;
        logic [167:0] grb = '0;
        logic [23:0]  w, rgb;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (rstn_v[d] !== 1'b1) begin
                act = 0; pds = ds_v[d]; pdone = 1'b0;
                continue;
            end
            if (ds_v[d] === 1'b1 && pds === 1'b0) begin
                if (!act) begin
                    act = 1; start_c = cyc; gap = cyc - fall_c; nb = 0; grb = '0;
                end else begin
                    chk($sformatf("dut%0d_low_width_bit%0d", d, nb), cyc - fall_c, CL);
                end
                rise_c = cyc;
            end
            if (ds_v[d] === 1'b0 && pds === 1'b1 && act) begin
                hw = cyc - rise_c;
                checks++;
                if (hw != C0H && hw != C1H) begin
                    failures++;
                    $display("FAIL dut%0d_high_width_bit%0d: got %0d expected %0d or %0d", d, nb, hw, C0H, C1H);
                end
                if (nb < 168) grb[167 - nb] = (hw == C1H);
                nb++;
                fall_c = cyc;
            end
            if (done_v[d] === 1'b1) begin
                chk($sformatf("dut%0d_done_busy_exclusive", d), busy_v[d], 0);
                if (pdone === 1'b1) begin
                    chk($sformatf("dut%0d_done_one_cycle", d), 1, 0);
                end else begin
                    have = 0;
                    if (d == 0) begin if (q0.size() != 0) begin e = q0.pop_front(); have = 1; end end
                    else        begin if (q1.size() != 0) begin e = q1.pop_front(); have = 1; end end
                    if (!have) begin
                        chk($sformatf("dut%0d_unexpected_done", d), 1, 0);
                    end else begin
                        chk($sformatf("dut%0d_bit_count", d), nb, e.nleds * 24);
                        for (int i = 0; i < int'(e.nleds); i++) begin
                            w   = grb[167 - i*24 -: 24];
                            rgb = {w[15:8], w[23:16], w[7:0]};
                            chk($sformatf("dut%0d_led%0d_color", d, i), rgb, e.cols[i*24 +: 24]);
                        end
                        chk($sformatf("dut%0d_frame_len", d), cyc - start_c, e.len);
                        if (e.gap != 0) chk($sformatf("dut%0d_frame_gap", d), gap, e.gap);
                    end
                end
                act = 0;
            end
            pds = ds_v[d];
            pdone = done_v[d];
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic wait_done(input int d, input int unsigned budget);
        int unsigned n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done_v[d] !== 1'b1 && n < budget);
        if (done_v[d] !== 1'b1) begin
            checks++; failures++;
            $display("FAIL dut%0d_timeout_done: got no done in %0d cycles expected a done pulse", d, budget);
        end
    endtask

    task automatic wait_rises(input int d, input int unsigned cnt, input int unsigned budget);
        int unsigned n = 0, r = 0;
        logic p = ds_v[d];
        while (r < cnt && n < budget) begin
            @(negedge clk);
            n++;
            if (ds_v[d] === 1'b1 && p === 1'b0) r++;
            p = ds_v[d];
        end
        if (r < cnt) begin
            checks++; failures++;
            $display("FAIL dut%0d_timeout_rises: got %0d rises expected %0d", d, r, cnt);
        end
    endtask

    localparam logic [167:0] T3 = {24'hA5C35A, 24'h000000, 24'hFFFFFF, 24'h0000FF,
                                   24'h00FF00, 24'hFF0000, 24'h112233};
    localparam logic [167:0] T4 = {24'h3C3C3C, 24'h00FFFF, 24'h800000, 24'h000001,
                                   24'hDEF012, 24'h789ABC, 24'h123456};

    initial begin
        bit saw_done;
        rstn1 = 1'b0; start1 = 1'b1; col1 = 24'hFF0000;
        rstn7 = 1'b0; start7 = 1'b0; col7 = '0;

        // Reset held with start asserted
        repeat (5) begin
            @(posedge clk); #1;
            chk("reset_outputs_dut1", {ds1, busy1, done1}, 3'b000);
            chk("reset_outputs_dut7", {ds7, busy7, done7}, 3'b000);
        end
        rstn1 = 1'b1;
        push(0, {144'd0, 24'hFF0000}, 1, 6424, 0);
        @(posedge clk); #1;
        chk("first_high_ds", ds1, 1);
        chk("first_high_busy", busy1, 1);
        start1 = 1'b0;
        wait_done(0, 8000);

        // Back-to-back frames with start held
        col1 = 24'h81C3E7;
        start1 = 1'b1;
        push(0, {144'd0, 24'h81C3E7}, 1, frame_len({144'd0, 24'h81C3E7}, 1), 0);
        push(0, {144'd0, 24'h81C3E7}, 1, frame_len({144'd0, 24'h81C3E7}, 1), CL + CRST + 1);
        push(0, {144'd0, 24'h81C3E7}, 1, frame_len({144'd0, 24'h81C3E7}, 1), CL + CRST + 1);
        wait_done(0, 8000);
        wait_done(0, 8000);
        wait_done(0, 8000);
        start1 = 1'b0;
        repeat (10) @(negedge clk);
        chk("dut1_idle_after_repeat", busy1, 0);

        // Seven-LED frame
        @(posedge clk); #1;
        rstn7 = 1'b1; col7 = T3; start7 = 1'b1;
        push(1, T3, 7, frame_len(T3, 7), 0);
        @(posedge clk); #1;
        start7 = 1'b0;
        wait_done(1, 20000);

        // Abort during LED3 bit 10
        @(posedge clk); #1;
        start7 = 1'b1;
        @(posedge clk); #1;
        start7 = 1'b0;
        wait_rises(1, 83, 10000);
        @(posedge clk); #1;
        rstn7 = 1'b0;
        @(posedge clk); #1;
        chk("abort_outputs", {ds7, busy7, done7}, 3'b000);
        rstn7 = 1'b1;
        saw_done = 0;
        repeat (200) begin
            @(negedge clk);
            if (done7 === 1'b1) saw_done = 1;
        end
        chk("abort_no_done", saw_done, 0);
        chk("abort_idle", {ds7, busy7}, 2'b00);

        // Snapshot held against mid-frame start and colour change
        @(posedge clk); #1;
        col7 = T4; start7 = 1'b1;
        push(1, T4, 7, frame_len(T4, 7), 0);
        @(posedge clk); #1;
        start7 = 1'b0;
        repeat (2000) @(posedge clk);
        #1;
        start7 = 1'b1; col7 = ~T4;
        @(posedge clk); #1;
        start7 = 1'b0;
        wait_done(1, 20000);
        repeat (50) @(negedge clk);
        chk("second_start_ignored", {ds7, busy7}, 2'b00);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(64'd20 * 64'd200_000);
        $display("FAIL watchdog: got no finish expected completion within 200000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
